// File: rtl/lbp_window_engine.sv
// Local Binary Pattern engine: walks a raster gray image held in external RAM
// through a sliding 3x3 window and emits one 8-bit LBP code per centre pixel.
module lbp_window_engine #(
  parameter int XW          = 7,
  parameter int YW          = 7,
  parameter int PIX_W       = 8,
  parameter int BORDER_MODE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PIX_W-1:0]   thresh,
  output logic [YW+XW-1:0]   gray_addr,
  output logic               gray_req,
  input  logic               gray_ready,
  input  logic [PIX_W-1:0]   gray_data,
  output logic [YW+XW-1:0]   lbp_addr,
  output logic               lbp_valid,
  input  logic               lbp_ready,
  output logic [7:0]         lbp_data,
  output logic               busy,
  output logic               finish
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SLIDE, S_CALC, S_OUT, S_DONE
  } state_t;

  localparam logic [XW-1:0] C0 = XW'((BORDER_MODE != 0) ? 0 : 1);
  localparam logic [XW-1:0] C1 = XW'((2 ** XW) - ((BORDER_MODE != 0) ? 1 : 2));
  localparam logic [YW-1:0] R0 = YW'((BORDER_MODE != 0) ? 0 : 1);
  localparam logic [YW-1:0] R1 = YW'((2 ** YW) - ((BORDER_MODE != 0) ? 1 : 2));

  // Window slot = col*3 + row; this maps LBP bit b to the slot holding its neighbour.
  localparam int NB_SLOT [8] = '{0, 3, 6, 1, 7, 2, 5, 8};

  state_t             r_state;
  state_t             w_next;
  logic [YW-1:0]      r_row;
  logic [XW-1:0]      r_col;
  logic [PIX_W-1:0]   r_thresh;
  logic [PIX_W-1:0]   r_win [9];
  logic [3:0]         r_req_idx;
  logic [3:0]         r_pend_slot;
  logic               r_pend;

  logic [1:0]         w_col_sel;
  logic [1:0]         w_row_sel;
  logic [XW-1:0]      w_ncol;
  logic [YW-1:0]      w_nrow;
  logic [PIX_W:0]     w_ref;
  logic [7:0]         w_code;
  logic               w_accept;
  logic               w_last_cap;
  logic               w_out_hs;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_start_frame;

  assign w_accept      = gray_req && gray_ready;
  assign w_last_cap    = r_pend && (r_pend_slot == 4'd8);
  assign w_out_hs      = lbp_valid && lbp_ready;
  assign w_last_col    = (r_col == C1);
  assign w_last_row    = (r_row == R1);
  assign w_start_frame = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE:  if (start) w_next = S_FILL;
      S_FILL, S_SLIDE: if (w_last_cap) w_next = S_CALC;
      S_CALC:          w_next = S_OUT;
      S_OUT: begin
        if (w_out_hs) begin
          if (!w_last_col)      w_next = S_SLIDE;
          else if (!w_last_row) w_next = S_FILL;
          else                  w_next = S_DONE;
        end
      end
      default:         w_next = S_IDLE;
    endcase
  end

  always_comb begin
    gray_req  = 1'b0;
    lbp_valid = 1'b0;
    busy      = 1'b0;
    finish    = 1'b0;
    case (r_state)
      S_FILL, S_SLIDE: begin
        gray_req = (r_req_idx != 4'd9);
        busy     = 1'b1;
      end
      S_CALC: busy = 1'b1;
      S_OUT: begin
        lbp_valid = 1'b1;
        busy      = 1'b1;
      end
      S_DONE:  finish = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    if (r_req_idx >= 4'd6) begin
      w_col_sel = 2'd2;
      w_row_sel = 2'(r_req_idx - 4'd6);
    end else if (r_req_idx >= 4'd3) begin
      w_col_sel = 2'd1;
      w_row_sel = 2'(r_req_idx - 4'd3);
    end else begin
      w_col_sel = 2'd0;
      w_row_sel = 2'(r_req_idx);
    end
  end

  // Edge clamping can only trigger in border mode; the interior raster never touches an edge.
  always_comb begin
    w_ncol = r_col;
    if ((w_col_sel == 2'd0) && (r_col != '0))      w_ncol = r_col - 1'b1;
    else if ((w_col_sel == 2'd2) && (r_col != '1)) w_ncol = r_col + 1'b1;
    w_nrow = r_row;
    if ((w_row_sel == 2'd0) && (r_row != '0))      w_nrow = r_row - 1'b1;
    else if ((w_row_sel == 2'd2) && (r_row != '1)) w_nrow = r_row + 1'b1;
  end

  assign gray_addr = gray_req ? {w_nrow, w_ncol} : '0;

  // One guard bit keeps p + thresh from wrapping.
  always_comb begin
    w_code = '0;
    w_ref  = {1'b0, r_win[4]} + {1'b0, r_thresh};
    for (int b = 0; b < 8; b++) w_code[b] = ({1'b0, r_win[NB_SLOT[b]]} >= w_ref);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_thresh    <= '0;
      r_req_idx   <= '0;
      r_pend      <= 1'b0;
      r_pend_slot <= '0;
      // NOTE: the window is nine plain registers, so it is cleared with the rest of the state.
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      lbp_data    <= '0;
      lbp_addr    <= '0;
    end else begin
      // NOTE: non-blocking updates let every register see pre-edge values of the others.
      r_pend <= w_accept;
      if (w_accept) begin
        r_pend_slot <= r_req_idx;
        r_req_idx   <= r_req_idx + 4'd1;
      end
      if (r_pend) r_win[r_pend_slot] <= gray_data;

      if (w_start_frame) begin
        r_row     <= R0;
        r_col     <= C0;
        r_thresh  <= thresh;
        r_req_idx <= 4'd0;
      end

      if (r_state == S_CALC) begin
        lbp_data <= w_code;
        lbp_addr <= {r_row, r_col};
      end

      if ((r_state == S_OUT) && w_out_hs && !(w_last_col && w_last_row)) begin
        if (w_last_col) begin
          r_row     <= r_row + 1'b1;
          r_col     <= C0;
          r_req_idx <= 4'd0;
        end else begin
          // Reuse columns c and c+1 as the new c-1 and c; only column c+1 is refetched.
          r_col     <= r_col + 1'b1;
          r_req_idx <= 4'd6;
          for (int i = 0; i < 6; i++) r_win[i] <= r_win[i+3];
        end
      end
    end
  end

endmodule
